reg_mem_arbiter: RTL and testbench

//  Shares the single-port settings register memory between two requesters: port 0 (UART command handler) and port 1 (gamma datapath LUT/settings fetch).

---
 rtl/reg_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_reg_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: shares the single-port settings register memory between
// port 0 (UART command handler) and port 1 (gamma datapath fetch).
// Round-robin grant, one transaction in flight, read-only window protection,
// out-of-range rejection and memory clear sequencing.
// Ports:
//   clk, rst                  core clock, async active-high reset
//   reqN_valid/we/addr/wdata  request from port N (held until reqN_ready)
//   reqN_ready                combinational accept
//   reqN_done/err/rdata       registered completion pulse, error, read data
//   clr_req / clr_ack         memory clear request level / issue pulse
//   mem_addr/data_in/we/reset registered memory controls
//   mem_data_out              memory read data, READ_LAT cycles after mem_addr
module reg_mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned RO_DEPTH   = 128,
   parameter int unsigned RW_DEPTH   = 128,
   parameter int unsigned READ_LAT   = 1,
   localparam int unsigned AW        = $clog2(RO_DEPTH + RW_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [AW-1:0]         req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  req0_done,
   output logic                  req0_err,
   output logic [DATA_WIDTH-1:0] req0_rdata,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [AW-1:0]         req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  req1_done,
   output logic                  req1_err,
   output logic [DATA_WIDTH-1:0] req1_rdata,
   input  logic                  clr_req,
   output logic                  clr_ack,
   output logic [AW-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_reset
);

   localparam int unsigned TOTAL = RO_DEPTH + RW_DEPTH;
   localparam int unsigned CW    = $clog2(READ_LAT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

   state_t                state;
   logic [CW-1:0]         rdCnt;
   logic                  rrPtr;
   logic                  curPort;

   logic                  bothValid;
   logic                  grantValid;
   logic                  grantPort;
   logic                  reqWe;
   logic [AW-1:0]         reqAddr;
   logic [DATA_WIDTH-1:0] reqWdata;
   logic                  outRange;
   logic                  roHit;
   logic                  reject;

   // Grant selection and access checks for the cycle a request is accepted.
   always_comb begin
      bothValid  = req0_valid && req1_valid;
      grantValid = !rst && (state == IDLE) && !clr_req && (req0_valid || req1_valid);
      grantPort  = bothValid ? rrPtr : req1_valid;
      req0_ready = grantValid && !grantPort;
      req1_ready = grantValid && grantPort;
      reqWe      = grantPort ? req1_we    : req0_we;
      reqAddr    = grantPort ? req1_addr  : req0_addr;
      reqWdata   = grantPort ? req1_wdata : req0_wdata;
      // One extra bit so the total depth is representable even when it is 2**AW.
      outRange   = (AW+1)'(reqAddr) >= (AW+1)'(TOTAL);
      roHit      = reqWe && ((AW+1)'(reqAddr) < (AW+1)'(RO_DEPTH));
      reject     = outRange || roHit;
   end

   // Arbiter FSM with all memory and completion outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rdCnt       <= '0;
         rrPtr       <= 1'b0;
         curPort     <= 1'b0;
         req0_done   <= 1'b0;
         req0_err    <= 1'b0;
         req0_rdata  <= '0;
         req1_done   <= 1'b0;
         req1_err    <= 1'b0;
         req1_rdata  <= '0;
         clr_ack     <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_we      <= 1'b0;
         mem_reset   <= 1'b0;
      end else begin
         // Pulse outputs default low; rdata is only non-zero alongside done.
         req0_done  <= 1'b0;
         req0_err   <= 1'b0;
         req0_rdata <= '0;
         req1_done  <= 1'b0;
         req1_err   <= 1'b0;
         req1_rdata <= '0;
         clr_ack    <= 1'b0;
         mem_we     <= 1'b0;
         mem_reset  <= 1'b0;

         case (state)
            IDLE: begin
               if (clr_req) begin
                  mem_reset <= 1'b1;
                  clr_ack   <= 1'b1;
               end else if (grantValid) begin
                  if (bothValid) rrPtr <= ~grantPort;
                  curPort <= grantPort;
                  if (reject || reqWe) begin
                     // Rejects and writes complete in the cycle after accept.
                     if (grantPort) begin
                        req1_done <= 1'b1;
                        req1_err  <= reject;
                     end else begin
                        req0_done <= 1'b1;
                        req0_err  <= reject;
                     end
                     if (!reject) begin
                        mem_addr    <= reqAddr;
                        mem_data_in <= reqWdata;
                        mem_we      <= 1'b1;
                     end
                  end else begin
                     mem_addr <= reqAddr;
                     rdCnt    <= CW'(READ_LAT);
                     state    <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               // Stays READ_LAT cycles so RD_CAP lines up with valid read data.
               if (rdCnt == CW'(1)) state <= RD_CAP;
               else                 rdCnt <= rdCnt - CW'(1);
            end
            RD_CAP: begin
               if (curPort) begin
                  req1_done  <= 1'b1;
                  req1_rdata <= mem_data_out;
               end else begin
                  req0_done  <= 1'b1;
                  req0_rdata <= mem_data_out;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// tb_reg_mem_arbiter: directed bench for reg_mem_arbiter with a behavioural
// one-cycle-latency memory and a scoreboard of expected completions.
// RW_DEPTH is reduced to 120 so the out-of-range window is reachable with
// the 8-bit address bus (valid addresses 0x00..0xF7).
module tb_reg_mem_arbiter;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 8;
   localparam int unsigned RW_D  = 120;

   typedef struct packed {
      logic          port;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid, req0_we, req0_ready, req0_done, req0_err;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_rdata;
   logic          req1_valid, req1_we, req1_ready, req1_done, req1_err;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_rdata;
   logic          clr_req, clr_ack, mem_we, mem_reset;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in, mem_data_out;

   logic [DW-1:0] mem [256];
   exp_t          sbQ [$];
   int            nAssert = 0;
   int            nFail   = 0;
   bit            ok;

   always #5 clk = ~clk;

   reg_mem_arbiter #(
      .DATA_WIDTH(DW), .RO_DEPTH(128), .RW_DEPTH(RW_D), .READ_LAT(1)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_err(req0_err), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_err(req1_err), .req1_rdata(req1_rdata),
      .clr_req(clr_req), .clr_ack(clr_ack),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
      .mem_data_out(mem_data_out), .mem_reset(mem_reset)
   );

   // Register memory: synchronous write/clear, one-cycle registered read.
   always @(posedge clk) begin
      if (rst || mem_reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_data_in;
      end
      mem_data_out <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic p, input logic e, input logic [DW-1:0] d);
      exp_t x;
      x.port  = p;
      x.err   = e;
      x.rdata = d;
      sbQ.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady(output bit found);
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (req0_ready || req1_ready) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic waitDone(output bit found);
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (req0_done || req1_done) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Scoreboard: every completion must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (req0_done || req1_done)) begin
         if (sbQ.size() == 0) begin
            nAssert++;
            nFail++;
            $error("FAIL sb_unexpected_done observed done1/done0=%b%b expected none",
                   req1_done, req0_done);
         end else begin
            e = sbQ.pop_front();
            chk("sb_port", {30'd0, req1_done, req0_done}, e.port ? 32'd2 : 32'd1);
            if (e.port) begin
               chk("sb_err1",   32'(req1_err),   32'(e.err));
               chk("sb_rdata1", 32'(req1_rdata), 32'(e.rdata));
               chk("sb_quiet0", {15'd0, req0_err, req0_rdata}, 32'd0);
            end else begin
               chk("sb_err0",   32'(req0_err),   32'(e.err));
               chk("sb_rdata0", 32'(req0_rdata), 32'(e.rdata));
               chk("sb_quiet1", {15'd0, req1_err, req1_rdata}, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
      clr_req = 0;

      // Reset state
      step(); step();
      chk("rst_outputs", {1'b0, mem_addr, mem_data_in, mem_we, mem_reset, clr_ack,
                          req0_done, req0_err, req1_done, req1_err}, 32'd0);
      chk("rst_rdata", {req0_rdata, req1_rdata}, 32'd0);
      req0_valid = 1; #1;
      chk("rst_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      req0_valid = 0;
      rst = 0;
      step();

      // 1: accepted write
      req0_valid = 1; req0_we = 1; req0_addr = 8'h90; req0_wdata = 16'hBEEF; #1;
      chk("t1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(0, 0, 16'h0);
      step();
      req0_valid = 0;
      chk("t1_mem", {7'd0, mem_we, mem_addr, mem_data_in}, {7'd0, 1'b1, 8'h90, 16'hBEEF});
      chk("t1_done", {30'd0, req0_done, req0_err}, 32'd2);
      step();
      chk("t1_pulses", {30'd0, mem_we, req0_done}, 32'd0);

      // 2: read with READ_LAT=1, plus a request withdrawn while busy
      req1_valid = 1; req1_we = 0; req1_addr = 8'h90; #1;
      chk("t2_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
      push(1, 0, 16'hBEEF);
      step();
      req1_valid = 0;
      req0_valid = 1; req0_we = 1; req0_addr = 8'h91; req0_wdata = 16'h5555; #1;
      chk("t2_c1", {22'd0, mem_we, mem_addr, req1_done}, {22'd0, 1'b0, 8'h90, 1'b0});
      chk("t2_busy_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      chk("t2_c2_nodone", {30'd0, req1_done, req0_ready}, 32'd0);
      req0_valid = 0;
      step();
      chk("t2_done", {13'd0, req1_done, req1_err, mem_we, req1_rdata}, {13'd0, 3'b100, 16'hBEEF});
      chk("t2_port0_quiet", {15'd0, req0_done | req0_err, req0_rdata}, 32'd0);
      step();

      // 3: contention, grants alternate starting at port 0
      req0_valid = 1; req0_we = 0; req0_addr = 8'h90;
      req1_valid = 1; req1_we = 0; req1_addr = 8'h90;
      for (int k = 0; k < 4; k++) begin
         waitReady(ok);
         chk("t3_ready_seen", 32'(ok), 32'd1);
         chk("t3_grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
         push(1'(k % 2), 0, 16'hBEEF);
         step();
      end
      req0_valid = 0; req1_valid = 0;
      waitDone(ok);
      chk("t3_drain", 32'(ok), 32'd1);
      step();

      // 4: protection and range checks
      req0_valid = 1; req0_we = 1; req0_addr = 8'h05; req0_wdata = 16'hDEAD; #1;
      chk("t4_ro_ready", 32'(req0_ready), 32'd1);
      push(0, 1, 16'h0);
      step();
      req0_valid = 0;
      chk("t4_ro_write", {29'd0, mem_we, req0_done, req0_err}, 32'd3);
      step();
      req0_valid = 1; req0_we = 0; req0_addr = 8'h05; #1;
      push(0, 0, 16'h0);
      step();
      req0_valid = 0;
      waitDone(ok);
      chk("t4_ro_read_done", 32'(ok), 32'd1);
      chk("t4_ro_read_err", 32'(req0_err), 32'd0);
      step();
      req1_valid = 1; req1_we = 0; req1_addr = 8'hF8; #1;
      chk("t4_oor_ready", 32'(req1_ready), 32'd1);
      push(1, 1, 16'h0);
      step();
      req1_valid = 0;
      chk("t4_oor_hold", {23'd0, mem_we, mem_addr}, {23'd0, 1'b0, 8'h05});
      chk("t4_oor_err", {14'd0, req1_done, req1_err, req1_rdata}, {14'd0, 2'b11, 16'h0});
      step();
      req0_valid = 1; req0_we = 1; req0_addr = 8'hFF; req0_wdata = 16'h7777; #1;
      push(0, 1, 16'h0);
      step();
      req0_valid = 0;
      chk("t4_oor_write", {30'd0, mem_we, req0_err}, 32'd1);
      step();
      req0_valid = 1; req0_we = 1; req0_addr = 8'h80; req0_wdata = 16'h1234; #1;
      chk("t4_b2b_ready1", 32'(req0_ready), 32'd1);
      push(0, 0, 16'h0);
      step();
      chk("t4_b2b_1", {7'd0, mem_we, mem_addr, mem_data_in}, {7'd0, 1'b1, 8'h80, 16'h1234});
      req0_addr = 8'h81; req0_wdata = 16'h5678; #1;
      chk("t4_b2b_ready2", 32'(req0_ready), 32'd1);
      push(0, 0, 16'h0);
      step();
      req0_valid = 0;
      chk("t4_b2b_2", {7'd0, mem_we, mem_addr, mem_data_in}, {7'd0, 1'b1, 8'h81, 16'h5678});
      step();
      req1_valid = 1; req1_we = 0; req1_addr = 8'h80; #1;
      push(1, 0, 16'h1234);
      step();
      req1_valid = 0;
      waitDone(ok);
      chk("t4_rw_readback", 32'(ok), 32'd1);
      step();

      // 5: clear has priority, then deferred behind an in-flight read
      clr_req = 1;
      req0_valid = 1; req0_we = 0; req0_addr = 8'h80;
      req1_valid = 1; req1_we = 0; req1_addr = 8'h81; #1;
      chk("t5_clr_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      chk("t5_clr_pulse", {30'd0, mem_reset, clr_ack}, 32'd3);
      clr_req = 0; #1;
      chk("t5_grant_after_clr", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(0, 0, 16'h0);
      step();
      req0_valid = 0;
      chk("t5_pulse_once", {30'd0, mem_reset, clr_ack}, 32'd0);
      chk("t5_busy_noready", 32'(req1_ready), 32'd0);
      clr_req = 1;
      step();
      chk("t5_clr_deferred", {29'd0, mem_reset, clr_ack, req1_ready}, 32'd0);
      step();
      chk("t5_read_first", {29'd0, req0_done, mem_reset, req1_ready}, 32'd4);
      step();
      chk("t5_clr_after_read", {30'd0, mem_reset, clr_ack}, 32'd3);
      clr_req = 0; #1;
      chk("t5_grant_p1", {30'd0, req1_ready, req0_ready}, 32'd2);
      push(1, 0, 16'h0);
      step();
      req1_valid = 0;
      waitDone(ok);
      chk("t5_p1_done", 32'(ok), 32'd1);
      step();

      // 6: async reset while the read is waiting on memory
      req0_valid = 1; req0_we = 0; req0_addr = 8'h90; #1;
      chk("t6_ready", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 0;
      chk("t6_c1_addr", 32'(mem_addr), 32'h90);
      #2 rst = 1;
      #1;
      chk("t6_async_rst", {1'b0, mem_addr, mem_data_in, mem_we, mem_reset, clr_ack,
                           req0_done, req0_err, req1_done, req1_err}, 32'd0);
      step(); step();
      chk("t6_no_done", {30'd0, req1_done, req0_done}, 32'd0);
      rst = 0;
      step();
      req0_valid = 1; req0_we = 0; req0_addr = 8'h90;
      req1_valid = 1; req1_we = 0; req1_addr = 8'h90; #1;
      chk("t6_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      push(0, 0, 16'h0);
      step();
      req0_valid = 0; req1_valid = 0;
      waitDone(ok);
      chk("t6_done", 32'(ok), 32'd1);
      repeat (3) step();

      chk("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
